// File: rtl/axi_mem_slave_if.sv
// AXI3 channel bundle between an AXI master and axi_mem_slave.
// Clock and reset are not part of the bundle.
interface axi_mem_slave_if #(
   parameter int WIDTH_ID = 4,
   parameter int WIDTH_AD = 32,
   parameter int WIDTH_DA = 32,
   parameter int WIDTH_DS = WIDTH_DA / 8
);
   logic [WIDTH_ID-1:0] AWID;
   logic [WIDTH_AD-1:0] AWADDR;
   logic [3:0]          AWLEN;
   logic [2:0]          AWSIZE;
   logic [1:0]          AWBURST;
   logic                AWVALID;
   logic                AWREADY;

   logic [WIDTH_ID-1:0] WID;
   logic [WIDTH_DA-1:0] WDATA;
   logic [WIDTH_DS-1:0] WSTRB;
   logic                WLAST;
   logic                WVALID;
   logic                WREADY;

   logic [WIDTH_ID-1:0] BID;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;

   logic [WIDTH_ID-1:0] ARID;
   logic [WIDTH_AD-1:0] ARADDR;
   logic [3:0]          ARLEN;
   logic [2:0]          ARSIZE;
   logic [1:0]          ARBURST;
   logic                ARVALID;
   logic                ARREADY;

   logic [WIDTH_ID-1:0] RID;
   logic [WIDTH_DA-1:0] RDATA;
   logic [1:0]          RRESP;
   logic                RLAST;
   logic                RVALID;
   logic                RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
      output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
      input BID, BRESP, BVALID, output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
      input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
   );

   modport slave (
      input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
      input WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
      output BID, BRESP, BVALID, input BREADY,
      input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
   );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI3 slave backed by a byte-strobed RAM; independent write and read burst engines.
// Define AXI_MEM_SLV_DECERR_EN to decode upper address bits against P_ADDR_BASE (DECERR on miss).
module axi_mem_slave #(
   parameter int                  WIDTH_ID    = 4,
   parameter int                  WIDTH_AD    = 32,
   parameter int                  WIDTH_DA    = 32,
   parameter int                  WIDTH_DS    = WIDTH_DA / 8,
   parameter int                  WIDTH_DSB   = $clog2(WIDTH_DS),
   parameter int                  ADDR_LENGTH = 16,
   parameter logic [WIDTH_AD-1:0] P_ADDR_BASE = 'h8000_0000
) (
   input logic            ACLK,
   input logic            ARESETn,
   axi_mem_slave_if.slave bus
);
   localparam int ROW_W = ADDR_LENGTH - WIDTH_DSB;
   localparam int DEPTH = 2 ** ROW_W;

`ifdef AXI_MEM_SLV_DECERR_EN
   localparam bit DECODE_EN = 1'b1;
`else
   localparam bit DECODE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   // FIXED holds, WRAP stays inside the aligned (len+1)*size window, everything else increments.
   function automatic logic [WIDTH_AD-1:0] next_addr(input logic [WIDTH_AD-1:0] addr,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst,
                                                     input logic [3:0] len);
      logic [WIDTH_AD-1:0] step, incr, wmask;
      step  = WIDTH_AD'(1) << size;
      incr  = (addr & ~(step - WIDTH_AD'(1))) + step;
      wmask = (WIDTH_AD'({1'b0, len} + 5'd1) << size) - WIDTH_AD'(1);
      case (burst)
         2'b00:   next_addr = addr;
         2'b10:   next_addr = (addr & ~wmask) | (incr & wmask);
         default: next_addr = incr;
      endcase
   endfunction

   logic [WIDTH_DA-1:0] mem [DEPTH];

   w_state_t            w_state, w_next;
   logic [WIDTH_AD-1:0] w_addr;
   logic [3:0]          w_len, w_cnt;
   logic [2:0]          w_size;
   logic [1:0]          w_burst;
   logic                w_miss, aw_miss, aw_hs, w_hs, b_hs;

   r_state_t            r_state, r_next;
   logic [WIDTH_AD-1:0] r_addr, r_load_addr;
   logic [3:0]          r_len, r_cnt, r_load_cnt;
   logic [2:0]          r_size;
   logic [1:0]          r_burst;
   logic                r_miss, ar_miss, ar_hs, r_hs, r_load;

   assign aw_hs = bus.AWVALID && bus.AWREADY;
   assign w_hs  = bus.WVALID && bus.WREADY;
   assign b_hs  = bus.BVALID && bus.BREADY;
   assign ar_hs = bus.ARVALID && bus.ARREADY;
   assign r_hs  = bus.RVALID && bus.RREADY;

   assign aw_miss = DECODE_EN &&
                    (bus.AWADDR[WIDTH_AD-1:ADDR_LENGTH] != P_ADDR_BASE[WIDTH_AD-1:ADDR_LENGTH]);
   assign ar_miss = DECODE_EN &&
                    (bus.ARADDR[WIDTH_AD-1:ADDR_LENGTH] != P_ADDR_BASE[WIDTH_AD-1:ADDR_LENGTH]);

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && (w_cnt == w_len)) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state     <= W_IDLE;
         bus.AWREADY <= 1'b0;
         bus.WREADY  <= 1'b0;
         bus.BVALID  <= 1'b0;
         bus.BID     <= '0;
         bus.BRESP   <= '0;
         w_addr      <= '0;
         w_len       <= '0;
         w_cnt       <= '0;
         w_size      <= '0;
         w_burst     <= '0;
         w_miss      <= 1'b0;
      end else begin
         w_state     <= w_next;
         bus.AWREADY <= (w_next == W_IDLE);
         bus.WREADY  <= (w_next == W_DATA);
         bus.BVALID  <= (w_next == W_RESP);
         if (aw_hs) begin
            w_addr    <= bus.AWADDR;
            w_len     <= bus.AWLEN;
            w_size    <= bus.AWSIZE;
            w_burst   <= bus.AWBURST;
            w_cnt     <= '0;
            w_miss    <= aw_miss;
            bus.BID   <= bus.AWID;
            bus.BRESP <= aw_miss ? 2'b11 : 2'b00;
         end
         if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
            w_cnt  <= w_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_hs && !w_miss) begin
         for (int unsigned i = 0; i < WIDTH_DS; i++) begin
            if (bus.WSTRB[i]) mem[w_addr[ADDR_LENGTH-1:WIDTH_DSB]][i*8 +: 8] <= bus.WDATA[i*8 +: 8];
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_FETCH;
         R_FETCH: r_next = R_DATA;
         R_DATA:  if (r_hs && bus.RLAST) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // The RAM row for the next beat is read on the same edge that retires the current one,
   // so a continuously ready master sees one beat per clock.
   always_comb begin
      r_load_addr = r_addr;
      r_load_cnt  = '0;
      if (r_state == R_DATA) begin
         r_load_addr = next_addr(r_addr, r_size, r_burst, r_len);
         r_load_cnt  = r_cnt + 4'd1;
      end
   end

   assign r_load = (r_state == R_FETCH) || (r_hs && !bus.RLAST);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state     <= R_IDLE;
         bus.ARREADY <= 1'b0;
         bus.RVALID  <= 1'b0;
         bus.RLAST   <= 1'b0;
         bus.RID     <= '0;
         bus.RDATA   <= '0;
         bus.RRESP   <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_miss      <= 1'b0;
      end else begin
         r_state     <= r_next;
         bus.ARREADY <= (r_next == R_IDLE);
         bus.RVALID  <= (r_next == R_DATA);
         if (ar_hs) begin
            r_addr  <= bus.ARADDR;
            r_len   <= bus.ARLEN;
            r_size  <= bus.ARSIZE;
            r_burst <= bus.ARBURST;
            r_miss  <= ar_miss;
            bus.RID <= bus.ARID;
         end
         if (r_load) begin
            r_addr    <= r_load_addr;
            r_cnt     <= r_load_cnt;
            bus.RDATA <= r_miss ? '0 : mem[r_load_addr[ADDR_LENGTH-1:WIDTH_DSB]];
            bus.RRESP <= r_miss ? 2'b11 : 2'b00;
            bus.RLAST <= (r_load_cnt == r_len);
         end else if (r_hs) begin
            bus.RLAST <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, wrap, concurrency, reset, optional decode.
module tb_axi_mem_slave;
   localparam int LIMIT = 50;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] wbeat   [16];
   logic [3:0]  wstrb_b [16];
   logic [31:0] exp_rd  [16];
   longint      aw_time, ar_time;

   always #5 clk = ~clk;

   axi_mem_slave_if #(.WIDTH_ID(4), .WIDTH_AD(32), .WIDTH_DA(32)) bus ();

   axi_mem_slave #(
      .WIDTH_ID(4), .WIDTH_AD(32), .WIDTH_DA(32), .ADDR_LENGTH(16), .P_ADDR_BASE(32'h8000_0000)
   ) dut (
      .ACLK(clk), .ARESETn(rst_n), .bus(bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst, input logic [1:0] exp_resp);
      int t;
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = 3'd2;
      bus.AWBURST = burst; bus.AWVALID = 1'b1;
      t = 0;
      while (!bus.AWREADY && t < LIMIT) begin @(posedge clk); #1; t++; end
      if (t == LIMIT) check({tag, "_aw_timeout"}, t, 0);
      aw_time = $time;
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         bus.WID = id; bus.WDATA = wbeat[i]; bus.WSTRB = wstrb_b[i];
         bus.WLAST = (i == int'(len)); bus.WVALID = 1'b1;
         t = 0;
         while (!bus.WREADY && t < LIMIT) begin @(posedge clk); #1; t++; end
         if (t == LIMIT) check({tag, "_w_timeout"}, t, 0);
         @(posedge clk); #1;
      end
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
      bus.BREADY = 1'b1;
      t = 0;
      while (!bus.BVALID && t < LIMIT) begin @(posedge clk); #1; t++; end
      if (t == LIMIT) check({tag, "_b_timeout"}, t, 0);
      check({tag, "_bresp"}, bus.BRESP, exp_resp);
      check({tag, "_bid"}, bus.BID, id);
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
      check({tag, "_bvalid_clr"}, bus.BVALID, 0);
      check({tag, "_awready_back"}, bus.AWREADY, 1);
   endtask

   task automatic axi_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst, input bit toggle,
                           input logic [1:0] exp_resp);
      int t, beat;
      bit rr;
      bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = 3'd2;
      bus.ARBURST = burst; bus.ARVALID = 1'b1;
      t = 0;
      while (!bus.ARREADY && t < LIMIT) begin @(posedge clk); #1; t++; end
      if (t == LIMIT) check({tag, "_ar_timeout"}, t, 0);
      ar_time = $time;
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      beat = 0; t = 0; rr = 1'b1;
      while (beat <= int'(len) && t < LIMIT) begin
         bus.RREADY = toggle ? rr : 1'b1;
         if (bus.RVALID) begin
            check({tag, "_rdata"}, bus.RDATA, exp_rd[beat]);
            if (bus.RREADY) begin
               check({tag, "_rlast"}, bus.RLAST, (beat == int'(len)));
               check({tag, "_rid"}, bus.RID, id);
               check({tag, "_rresp"}, bus.RRESP, exp_resp);
               beat++;
            end
         end
         if (toggle) rr = !rr;
         @(posedge clk); #1;
         t++;
      end
      bus.RREADY = 1'b0;
      if (t == LIMIT) check({tag, "_r_timeout"}, t, 0);
      check({tag, "_rvalid_clr"}, bus.RVALID, 0);
      check({tag, "_arready_back"}, bus.ARREADY, 1);
   endtask

   initial begin
      int t;
      rst_n = 1'b0;
      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
      bus.AWVALID = 1'b0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
      bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
      bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
      for (int i = 0; i < 16; i++) wstrb_b[i] = 4'hF;

      repeat (2) @(posedge clk);
      #1;
      check("rst_awready", bus.AWREADY, 0);
      check("rst_wready", bus.WREADY, 0);
      check("rst_bvalid", bus.BVALID, 0);
      check("rst_arready", bus.ARREADY, 0);
      check("rst_rvalid", bus.RVALID, 0);
      check("rst_rlast", bus.RLAST, 0);
      check("rst_bid_bresp", {bus.BID, bus.BRESP}, 0);
      check("rst_rid_rresp", {bus.RID, bus.RRESP}, 0);
      check("rst_rdata", bus.RDATA, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_awready", bus.AWREADY, 1);
      check("idle_arready", bus.ARREADY, 1);

      // single beat
      wbeat[0] = 32'hDEAD_BEEF;
      axi_write("t1w", 4'h3, 32'h8000_1000, 4'd0, 2'b01, 2'b00);
      exp_rd[0] = 32'hDEAD_BEEF;
      axi_read("t1r", 4'h5, 32'h8000_1000, 4'd0, 2'b01, 1'b0, 2'b00);

      // INCR burst, read back with RREADY toggling
      for (int i = 0; i < 4; i++) begin wbeat[i] = 32'(i + 1); exp_rd[i] = 32'(i + 1); end
      axi_write("t2w", 4'h1, 32'h8000_2000, 4'd3, 2'b01, 2'b00);
      axi_read("t2r", 4'h2, 32'h8000_2000, 4'd3, 2'b01, 1'b1, 2'b00);

      // WRAP burst from the middle of a 16-byte window
      wbeat[0] = 32'hA; wbeat[1] = 32'hB; wbeat[2] = 32'hC; wbeat[3] = 32'hD;
      axi_write("t3w", 4'h6, 32'h8000_2008, 4'd3, 2'b10, 2'b00);
      exp_rd[0] = 32'hC; exp_rd[1] = 32'hD; exp_rd[2] = 32'hA; exp_rd[3] = 32'hB;
      axi_read("t3r", 4'h7, 32'h8000_2000, 4'd3, 2'b01, 1'b0, 2'b00);
      exp_rd[0] = 32'hA; exp_rd[1] = 32'hB; exp_rd[2] = 32'hC; exp_rd[3] = 32'hD;
      axi_read("t3wr", 4'h8, 32'h8000_2008, 4'd3, 2'b10, 1'b0, 2'b00);

      // byte strobe merge
      wbeat[0] = 32'h0000_AB00; wstrb_b[0] = 4'b0010;
      axi_write("t4w", 4'h4, 32'h8000_1000, 4'd0, 2'b01, 2'b00);
      wstrb_b[0] = 4'hF;
      exp_rd[0] = 32'hDEAD_ABEF;
      axi_read("t4r", 4'h4, 32'h8000_1000, 4'd0, 2'b01, 1'b0, 2'b00);

      // FIXED burst: every beat hits the same row
      wbeat[0] = 32'h1; wbeat[1] = 32'h2; wbeat[2] = 32'h3;
      axi_write("tfw", 4'h2, 32'h8000_5000, 4'd2, 2'b00, 2'b00);
      exp_rd[0] = 32'h3; exp_rd[1] = 32'h3;
      axi_read("tfr", 4'h2, 32'h8000_5000, 4'd1, 2'b00, 1'b0, 2'b00);

      // concurrent AW and AR to the same row: read sees the old word
      wbeat[0] = 32'h1111_1111;
      axi_write("t5pre", 4'h9, 32'h8000_3000, 4'd0, 2'b01, 2'b00);
      wbeat[0] = 32'h2222_2222;
      exp_rd[0] = 32'h1111_1111;
      fork
         axi_write("t5w", 4'h9, 32'h8000_3000, 4'd0, 2'b01, 2'b00);
         axi_read("t5r", 4'hA, 32'h8000_3000, 4'd0, 2'b01, 1'b0, 2'b00);
      join
      check("t5_same_hs", aw_time, ar_time);
      exp_rd[0] = 32'h2222_2222;
      axi_read("t5new", 4'hA, 32'h8000_3000, 4'd0, 2'b01, 1'b0, 2'b00);

      // reset during beat 2 of a 4-beat write
      for (int i = 0; i < 4; i++) wbeat[i] = 32'h0;
      axi_write("t6pre", 4'h1, 32'h8000_4000, 4'd3, 2'b01, 2'b00);
      bus.AWID = 4'h2; bus.AWADDR = 32'h8000_4000; bus.AWLEN = 4'd3; bus.AWSIZE = 3'd2;
      bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
      t = 0;
      while (!bus.AWREADY && t < LIMIT) begin @(posedge clk); #1; t++; end
      if (t == LIMIT) check("t6_aw_timeout", t, 0);
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      bus.WDATA = 32'h5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      t = 0;
      while (!bus.WREADY && t < LIMIT) begin @(posedge clk); #1; t++; end
      if (t == LIMIT) check("t6_w_timeout", t, 0);
      @(posedge clk); #1;
      bus.WDATA = 32'h6;
      rst_n = 1'b0;
      #1;
      check("t6_rst_awready", bus.AWREADY, 0);
      check("t6_rst_wready", bus.WREADY, 0);
      check("t6_rst_bvalid", bus.BVALID, 0);
      check("t6_rst_valids", {bus.ARREADY, bus.RVALID}, 0);
      bus.WVALID = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_awready_after", bus.AWREADY, 1);
      exp_rd[0] = 32'h5; exp_rd[1] = 32'h0; exp_rd[2] = 32'h0; exp_rd[3] = 32'h0;
      axi_read("t6r", 4'h3, 32'h8000_4000, 4'd3, 2'b01, 1'b0, 2'b00);

      // address decode / aliasing outside the base window
      wbeat[0] = 32'hA0A0_A0A0; wbeat[1] = 32'hB0B0_B0B0;
      axi_write("t7pre", 4'h5, 32'h8000_0000, 4'd1, 2'b01, 2'b00);
      wbeat[0] = 32'hC1C1_C1C1; wbeat[1] = 32'hC2C2_C2C2;
`ifdef AXI_MEM_SLV_DECERR_EN
      axi_write("t7w", 4'h6, 32'h9000_0000, 4'd1, 2'b01, 2'b11);
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      axi_read("t7miss", 4'h6, 32'h9000_0000, 4'd1, 2'b01, 1'b0, 2'b11);
      exp_rd[0] = 32'hA0A0_A0A0; exp_rd[1] = 32'hB0B0_B0B0;
      axi_read("t7ram", 4'h6, 32'h8000_0000, 4'd1, 2'b01, 1'b0, 2'b00);
`else
      axi_write("t7w", 4'h6, 32'h9000_0000, 4'd1, 2'b01, 2'b00);
      exp_rd[0] = 32'hC1C1_C1C1; exp_rd[1] = 32'hC2C2_C2C2;
      axi_read("t7alias", 4'h6, 32'h9000_0000, 4'd1, 2'b01, 1'b0, 2'b00);
      axi_read("t7ram", 4'h6, 32'h8000_0000, 4'd1, 2'b01, 1'b0, 2'b00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
